// File: rtl/sprite_rgb_fetch_if.sv
// Sprite ROM read port shared between the fetch stage (master) and the ROM (slave).
// The ROM is synchronous: mem_data reflects the address presented one edge earlier.
interface sprite_rgb_fetch_if #(
  parameter int ELEMENT = 5,
  parameter int ADDR_W  = 10
);
  logic [ELEMENT+ADDR_W-1:0] mem_addr;
  logic                      mem_rd;
  logic [8:0]                mem_data;

  modport master (output mem_addr, output mem_rd, input mem_data);
  modport slave  (input mem_addr, input mem_rd, output mem_data);
endinterface

// File: rtl/sprite_rgb_fetch.sv
// Sprite ROM fetch and colour compose stage of the VGA path: issue, delay, compose.
// RGB333 is expanded to 8 bits per channel with transparency and game-state backgrounds.
module sprite_rgb_fetch #(
  parameter int         ELEMENT      = 5,
  parameter int         ADDR_W       = 10,
  parameter logic [8:0] TRANSPARENT  = 9'h1FF,
  parameter logic [8:0] BG_PLAY      = 9'h000,
  parameter logic [8:0] BG_IDLE      = 9'h049,
  parameter logic [8:0] BG_OVER      = 9'h1C0,
  parameter int         BLINK_CYCLES = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    active,
  input  logic                    ready,
  input  logic [ELEMENT-1:0]      element,
  input  logic [ADDR_W-1:0]       address,
  input  logic [2:0]              stateGame,
  sprite_rgb_fetch_if.master      rom,
  output logic                    video_on,
  output logic [7:0]              r,
  output logic [7:0]              g,
  output logic [7:0]              b
);

  localparam int              CNT_W    = $clog2(BLINK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);
  localparam logic [2:0]      ST_PLAY  = 3'b001;
  localparam logic [2:0]      ST_OVER  = 3'b010;

  logic [CNT_W-1:0]          blinkCnt_q, blinkCnt_d;
  logic                      blink_q, blink_d;

  logic                      s0Active_q, s0Ready_q, s0Blink_q;
  logic [2:0]                s0State_q;
  logic [ELEMENT+ADDR_W-1:0] memAddr_q;
  logic                      memRd_q;

  logic                      s1Active_q, s1Ready_q, s1Blink_q;
  logic [2:0]                s1State_q;

  logic [8:0]                c9_d;
  logic                      videoOn_q;
  logic [7:0]                r_q, g_q, b_q;

  function automatic logic [7:0] expand(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  always_comb begin
    blinkCnt_d = blinkCnt_q;
    blink_d    = blink_q;
    if (stateGame != ST_OVER) begin
      blinkCnt_d = '0;
      blink_d    = 1'b1;
    end else if (blinkCnt_q == CNT_LAST) begin
      blinkCnt_d = '0;
      blink_d    = ~blink_q;
    end else begin
      blinkCnt_d = blinkCnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    c9_d = '0;
    if (s1Active_q) begin
      if (s1Ready_q && (rom.mem_data != TRANSPARENT)) begin
        c9_d = rom.mem_data;
      end else begin
        case (s1State_q)
          ST_PLAY: c9_d = BG_PLAY;
          ST_OVER: c9_d = s1Blink_q ? BG_OVER : 9'h000;
          default: c9_d = BG_IDLE;
        endcase
      end
    end
  end

  // The blink phase travels with each pixel, so a phase edge lands on the same
  // pixel boundary as the stateGame change that caused it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blinkCnt_q <= '0;
      blink_q    <= 1'b1;
      s0Active_q <= 1'b0;
      s0Ready_q  <= 1'b0;
      s0Blink_q  <= 1'b0;
      s0State_q  <= '0;
      memAddr_q  <= '0;
      memRd_q    <= 1'b0;
      s1Active_q <= 1'b0;
      s1Ready_q  <= 1'b0;
      s1Blink_q  <= 1'b0;
      s1State_q  <= '0;
      videoOn_q  <= 1'b0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
    end else begin
      blinkCnt_q <= blinkCnt_d;
      blink_q    <= blink_d;

      s0Active_q <= active;
      s0Ready_q  <= ready;
      s0Blink_q  <= blink_q;
      s0State_q  <= stateGame;
      memRd_q    <= ready & active;
      if (ready && active) begin
        memAddr_q <= {element, address};
      end

      s1Active_q <= s0Active_q;
      s1Ready_q  <= s0Ready_q;
      s1Blink_q  <= s0Blink_q;
      s1State_q  <= s0State_q;

      videoOn_q  <= s1Active_q;
      r_q        <= expand(c9_d[8:6]);
      g_q        <= expand(c9_d[5:3]);
      b_q        <= expand(c9_d[2:0]);
    end
  end

  assign rom.mem_addr = memAddr_q;
  assign rom.mem_rd   = memRd_q;
  assign video_on     = videoOn_q;
  assign r            = r_q;
  assign g            = g_q;
  assign b            = b_q;

endmodule

// File: tb/tb_sprite_rgb_fetch.sv
// Bench for sprite_rgb_fetch: a per-pixel colour model with a two-deep output queue,
// checked every cycle, plus directed literal checks of reset, keying, blanking and blink.
module tb_sprite_rgb_fetch;
  localparam int         ELEMENT      = 5;
  localparam int         ADDR_W       = 10;
  localparam int         BLINK_CYCLES = 4;
  localparam logic [8:0] KEY          = 9'h1FF;
  localparam logic [8:0] BG_PLAY      = 9'h000;
  localparam logic [8:0] BG_IDLE      = 9'h049;
  localparam logic [8:0] BG_OVER      = 9'h1C0;

  logic       clk = 1'b0;
  logic       reset;
  logic       active;
  logic       ready;
  logic [4:0] element;
  logic [9:0] address;
  logic [2:0] stateGame;
  logic       video_on;
  logic [7:0] r, g, b;

  int total = 0;
  int bad   = 0;
  bit modelLive = 1'b0;

  logic [8:0] romArr [0:32767];

  sprite_rgb_fetch_if #(.ELEMENT(ELEMENT), .ADDR_W(ADDR_W)) romBus ();

  sprite_rgb_fetch #(
    .ELEMENT(ELEMENT), .ADDR_W(ADDR_W), .TRANSPARENT(KEY), .BG_PLAY(BG_PLAY),
    .BG_IDLE(BG_IDLE), .BG_OVER(BG_OVER), .BLINK_CYCLES(BLINK_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .active(active), .ready(ready), .element(element),
    .address(address), .stateGame(stateGame), .rom(romBus),
    .video_on(video_on), .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (romBus.mem_rd) romBus.mem_data <= romArr[romBus.mem_addr];
  end

  typedef struct packed {
    logic       von;
    logic [8:0] c9;
  } pix_t;

  pix_t        pipe[$];
  pix_t        expPix;
  logic [14:0] expAddr;
  logic        expRd;
  int unsigned overRun;

  function automatic logic [7:0] scale(input logic [2:0] c);
    int v;
    v = (int'(c) * 255 + 3) / 7;
    return 8'(v);
  endfunction

  function automatic pix_t modelPixel(input logic act, input logic rdy, input logic [14:0] a,
                                      input logic [2:0] st, input bit blinkOn);
    pix_t p;
    p.von = act;
    p.c9  = 9'h000;
    if (act) begin
      if (rdy && romArr[a] != KEY) p.c9 = romArr[a];
      else if (st == 3'b001)       p.c9 = BG_PLAY;
      else if (st == 3'b010)       p.c9 = blinkOn ? BG_OVER : 9'h000;
      else                         p.c9 = BG_IDLE;
    end
    return p;
  endfunction

  // overRun counts consecutive earlier edges spent in game-over; blink is on for
  // even-numbered periods of BLINK_CYCLES within that run.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe.delete();
      pipe.push_back('0);
      pipe.push_back('0);
      expPix  = '0;
      expAddr = '0;
      expRd   = 1'b0;
      overRun = 0;
    end else begin
      pipe.push_back(modelPixel(active, ready, {element, address}, stateGame,
                                ((overRun / BLINK_CYCLES) % 2) == 0));
      expPix = pipe.pop_front();
      if (active && ready) expAddr = {element, address};
      expRd   = active & ready;
      overRun = (stateGame == 3'b010) ? overRun + 1 : 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  always @(negedge clk) begin
    if (modelLive && !reset) begin
      checkOutput("model_video_on", 32'(video_on), 32'(expPix.von));
      checkOutput("model_r", 32'(r), 32'(scale(expPix.c9[8:6])));
      checkOutput("model_g", 32'(g), 32'(scale(expPix.c9[5:3])));
      checkOutput("model_b", 32'(b), 32'(scale(expPix.c9[2:0])));
      checkOutput("model_mem_rd", 32'(romBus.mem_rd), 32'(expRd));
      checkOutput("model_mem_addr", 32'(romBus.mem_addr), 32'(expAddr));
    end
  end

  task automatic applyStimulus(input logic a, input logic rd, input logic [4:0] el,
                               input logic [9:0] ad, input logic [2:0] st);
    active    = a;
    ready     = rd;
    element   = el;
    address   = ad;
    stateGame = st;
    @(negedge clk);
  endtask

  task automatic checkRgb(input string name, input logic [7:0] er, input logic [7:0] eg,
                          input logic [7:0] eb, input logic ev);
    checkOutput({name, "_r"}, 32'(r), 32'(er));
    checkOutput({name, "_g"}, 32'(g), 32'(eg));
    checkOutput({name, "_b"}, 32'(b), 32'(eb));
    checkOutput({name, "_video_on"}, 32'(video_on), 32'(ev));
  endtask

  int rdCount;
  int vonCount;

  initial begin
    reset = 1'b1; active = 1'b0; ready = 1'b0; element = '0; address = '0; stateGame = 3'b000;
    for (int i = 0; i < 32768; i++) romArr[i] = 9'((i * 37 + 11) % 509);
    romArr[15'h0815] = 9'b111_000_100;
    romArr[15'h0816] = KEY;
    romArr[15'h0003] = 9'h0A5;
    romArr[15'h0400] = 9'b101_011_001;

    repeat (3) @(negedge clk);
    checkRgb("reset_hold", 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("reset_mem_rd", 32'(romBus.mem_rd), 32'd0);
    checkOutput("reset_mem_addr", 32'(romBus.mem_addr), 32'd0);
    reset = 1'b0;
    modelLive = 1'b1;

    applyStimulus(1'b0, 1'b0, 5'd0, 10'd0, 3'b001);
    applyStimulus(1'b0, 1'b0, 5'd0, 10'd0, 3'b001);

    rdCount = 0;
    vonCount = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 5'd1, 10'(i), 3'b001);
      if (i < 8) rdCount += int'(romBus.mem_rd);
      if (i >= 2) vonCount += int'(video_on);
      if (i == 2) checkRgb("stream_first", 8'hB6, 8'h6D, 8'h24, 1'b1);
    end
    checkOutput("stream_reads", 32'(rdCount), 32'd8);
    checkOutput("stream_outputs", 32'(vonCount), 32'd8);

    checkOutput("pre_reset_mem_rd", 32'(romBus.mem_rd), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkRgb("async_reset", 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("async_reset_mem_rd", 32'(romBus.mem_rd), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(1'b1, 1'b1, 5'd2, 10'h015, 3'b001);
    checkOutput("post_reset_mem_addr", 32'(romBus.mem_addr), 32'h0815);
    checkOutput("post_reset_mem_rd", 32'(romBus.mem_rd), 32'd1);
    applyStimulus(1'b1, 1'b1, 5'd2, 10'h016, 3'b001);
    applyStimulus(1'b1, 1'b1, 5'd2, 10'h016, 3'b000);
    checkRgb("sprite_pixel", 8'hFF, 8'h00, 8'h92, 1'b1);
    applyStimulus(1'b1, 1'b0, 5'd0, 10'd0, 3'b001);
    checkRgb("key_play", 8'h00, 8'h00, 8'h00, 1'b1);
    checkOutput("addr_hold", 32'(romBus.mem_addr), 32'h0816);
    applyStimulus(1'b0, 1'b1, 5'd3, 10'd0, 3'b001);
    checkRgb("key_idle", 8'h24, 8'h24, 8'h24, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd3, 10'd1, 3'b001);
    checkRgb("not_ready_play", 8'h00, 8'h00, 8'h00, 1'b1);

    vonCount = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) applyStimulus(1'b1, 1'b1, 5'd0, 10'd3, 3'b001);
      else       applyStimulus(1'b0, 1'b0, 5'd0, 10'd0, 3'b001);
      vonCount += int'(video_on);
      if (i == 0) checkRgb("blank_ready", 8'h00, 8'h00, 8'h00, 1'b0);
      if (i == 2) checkRgb("element0_pixel", 8'h49, 8'h92, 8'hB6, 1'b1);
      if (i == 5) checkOutput("pulse_fall", 32'(video_on), 32'd0);
    end
    checkOutput("pulse_width", 32'(vonCount), 32'd3);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd0, 10'd0, 3'b010);
      if (i == 2) checkOutput("blink_on_start", 32'(r), 32'hFF);
      if (i == 5) checkOutput("blink_on_end", 32'(r), 32'hFF);
      if (i == 6) checkOutput("blink_off_start", 32'(r), 32'h00);
      if (i == 9) checkOutput("blink_off_end", 32'(r), 32'h00);
    end
    applyStimulus(1'b1, 1'b0, 5'd0, 10'd0, 3'b000);
    applyStimulus(1'b1, 1'b0, 5'd0, 10'd0, 3'b000);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd0, 10'd0, 3'b010);
      if (i == 0) checkOutput("leave_idle", 32'(r), 32'h24);
      if (i == 2) checkOutput("reenter_on_start", 32'(r), 32'hFF);
      if (i == 5) checkOutput("reenter_on_end", 32'(r), 32'hFF);
      if (i == 6) checkOutput("reenter_off", 32'(r), 32'h00);
    end

    applyStimulus(1'b0, 1'b0, 5'd0, 10'd0, 3'b000);
    applyStimulus(1'b0, 1'b0, 5'd0, 10'd0, 3'b000);
    applyStimulus(1'b0, 1'b0, 5'd0, 10'd0, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
